// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions: polynomial length, taps,
// generator seed, checker state encoding and the feedback helper used by
// both the generator and the receive-side checker.
package prbs_pkg;

  localparam int PRBS31_LEN   = 31;
  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;

  localparam logic [PRBS31_LEN-1:0] PRBS31_SEED = 31'd1;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    SYNC    = 2'd1,
    LOCKED  = 2'd2
  } chk_state_e;

  // Next PRBS31 bit predicted from a history register whose bit 0 is newest.
  function automatic logic prbs31_fb(input logic [PRBS31_LEN-1:0] sr);
    return sr[PRBS31_TAP_A] ^ sr[PRBS31_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// 31-bit PRBS31 history register with tap XOR. load_ext_i selects whether
// the shifted-in bit comes from outside (checker acquiring) or from the
// register's own feedback (generator / free-running locked checker).
// rst_n is an asynchronous, active-high reset.
module prbs31_lfsr
  import prbs_pkg::*;
#(
  parameter logic [PRBS31_LEN-1:0] RST_VAL = PRBS31_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  load_ext_i,
  input  logic                  ext_bit_i,
  output logic [PRBS31_LEN-1:0] sr_o,
  output logic                  fb_o
);

  logic [PRBS31_LEN-1:0] sr_q, sr_d;

  assign fb_o = prbs31_fb(sr_q);
  assign sr_o = sr_q;

  // Shift left by one on enable; newest bit lands in bit 0.
  always_comb begin
    sr_d = sr_q;
    if (en_i) sr_d = {sr_q[PRBS31_LEN-2:0], (load_ext_i ? ext_bit_i : fb_o)};
  end

  // History register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) sr_q <= RST_VAL;
    else       sr_q <= sr_d;
  end

endmodule

// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 checker: self-synchronises to the incoming stream,
// declares lock after LOCK_CNT consecutive good predictions, then free-runs
// its local LFSR and counts errored / checked bits for BER readout.
// Optional build macro: PRBS_CHK_SAT_EN -- counters saturate at all-ones
// instead of wrapping.
// rst_n is an asynchronous, active-high reset.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 64,
  parameter int WIN         = 256,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(PRBS31_LEN);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRBS31_LEN - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(UNLOCK_ERRS - 1);

  chk_state_e            state_q;
  logic [FILL_W-1:0]     fill_q;
  logic [RUN_W-1:0]      run_q;
  logic [WIN_W-1:0]      win_q;
  logic [WERR_W-1:0]     werr_q;
  logic                  locked_q;
  logic                  err_pulse_q;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;

  logic [PRBS31_LEN-1:0] sr;
  logic                  expected;
  logic                  mismatch;
  logic                  sr_zero;
  logic                  in_lock;

  assign in_lock  = (state_q == LOCKED);
  assign mismatch = bit_in ^ expected;
  assign sr_zero  = (sr == '0);

  // Once locked the history takes its own prediction, so a channel error
  // only ever shows up once instead of echoing through both taps.
  prbs31_lfsr #(
    .RST_VAL ('0)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (bit_valid),
    .load_ext_i (!in_lock),
    .ext_bit_i  (bit_in),
    .sr_o       (sr),
    .fb_o       (expected)
  );

  // Counter increment: wraps by default, sticks at all-ones when saturating.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PRBS_CHK_SAT_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  // Acquire / sync / locked sequencing with registered lock and error pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ACQUIRE;
      fill_q      <= '0;
      run_q       <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      locked_q    <= in_lock;
      if (bit_valid) begin
        case (state_q)
          ACQUIRE: begin
            if (fill_q == FILL_LAST) begin
              state_q <= SYNC;
              fill_q  <= '0;
              run_q   <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          SYNC: begin
            // An all-zero history predicts zeros forever; never trust it.
            if (mismatch || sr_zero) begin
              run_q <= '0;
            end else if (run_q == RUN_LAST) begin
              state_q <= LOCKED;
              run_q   <= '0;
              win_q   <= '0;
              werr_q  <= '0;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end
          LOCKED: begin
            err_pulse_q <= mismatch;
            win_q       <= win_q + 1'b1;
            if (mismatch && (werr_q == WERR_LAST)) begin
              state_q <= ACQUIRE;
              fill_q  <= '0;
              win_q   <= '0;
              werr_q  <= '0;
            end else if (win_q == WIN_LAST) begin
              werr_q <= '0;
            end else if (mismatch) begin
              werr_q <= werr_q + 1'b1;
            end
          end
          default: state_q <= ACQUIRE;
        endcase
      end
    end
  end

  // BER counters: only bits checked while locked count; clr has priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (bit_valid && in_lock) begin
      bit_cnt_d = bump(bit_cnt_q);
      if (mismatch) err_cnt_d = bump(err_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: a PRBS31 generator drives two
// checkers (32-bit and 4-bit counters); expected outputs are queued as each
// bit is driven and compared after the following clock edge.
module tb_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, clr = 1'b0;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [31:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  always #5 clk = ~clk;

  prbs31_checker #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count));

  prbs31_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4));

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [31:0] e32;
    logic [31:0] b32;
    logic [3:0]  e4;
    logic [3:0]  b4;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0, nfail = 0;
  logic [30:0] gen;
  int          pre, win, werr;
  logic [31:0] m_e32, m_b32;
  logic [3:0]  m_e4, m_b4;
  logic        seen_lock;

  function automatic logic [31:0] inc32(input logic [31:0] v);
`ifdef PRBS_CHK_SAT_EN
    return (&v) ? v : v + 1;
`else
    return v + 1;
`endif
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] v);
`ifdef PRBS_CHK_SAT_EN
    return (&v) ? v : v + 4'd1;
`else
    return v + 4'd1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset both DUTs and the reference: generator seed 1, 95 bits to lock.
  task automatic do_reset();
    rst_n = 1'b1; bit_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    gen = 31'd1; pre = 95; win = 0; werr = 0;
    m_e32 = '0; m_b32 = '0; m_e4 = '0; m_b4 = '0;
  endtask

  // One cycle: drive a (possibly flipped) generator bit or an idle cycle.
  task automatic step(input logic v, input logic flip, input logic c);
    exp_t x;
    logic inc_b, inc_e;
    inc_b = 1'b0; inc_e = 1'b0;
    x.lk = (pre == 0);
    bit_valid = v; clr = c;
    if (v) begin
      bit_in = gen[30] ^ flip;
      gen = {gen[29:0], gen[30] ^ gen[27]};
      if (pre > 0) pre--;
      else begin
        inc_b = 1'b1; inc_e = flip;
        win++;
        if (flip) werr++;
        if (werr >= 8) begin pre = 95; win = 0; werr = 0; end
        else if (win == 256) begin win = 0; werr = 0; end
      end
    end else begin
      bit_in = 1'($urandom);
    end
    if (c) begin
      m_e32 = '0; m_b32 = '0; m_e4 = '0; m_b4 = '0;
    end else begin
      if (inc_b) begin m_b32 = inc32(m_b32); m_b4 = inc4(m_b4); end
      if (inc_e) begin m_e32 = inc32(m_e32); m_e4 = inc4(m_e4); end
    end
    x.pl = inc_e; x.e32 = m_e32; x.b32 = m_b32; x.e4 = m_e4; x.b4 = m_b4;
    sb.push_back(x);
    @(posedge clk); #1;
    clr = 1'b0; bit_valid = 1'b0;
    x = sb.pop_front();
    chk("locked",     {31'd0, locked},     {31'd0, x.lk});
    chk("err_pulse",  {31'd0, err_pulse},  {31'd0, x.pl});
    chk("err_count",  err_count,           x.e32);
    chk("bit_count",  bit_count,           x.b32);
    chk("locked4",    {31'd0, locked4},    {31'd0, x.lk});
    chk("err_pulse4", {31'd0, err_pulse4}, {31'd0, x.pl});
    chk("err_count4", {28'd0, err_count4}, {28'd0, x.e4});
    chk("bit_count4", {28'd0, bit_count4}, {28'd0, x.b4});
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Advance clean bits until the next loss-of-lock window begins.
  task automatic align();
    for (int i = 0; i < 300 && win != 0; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Raw bit, no reference model; only records whether lock ever appeared.
  task automatic raw(input logic b);
    bit_valid = 1'b1; bit_in = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    if (locked) seen_lock = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_locked",    {31'd0, locked},    32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_count", err_count,          32'd0);
    chk("rst_bit_count", bit_count,          32'd0);

    // Clean stream: lock rises after the 96th bit
    clean(95);
    chk("pre_lock_95", {31'd0, locked}, 32'd0);
    clean(1);
    chk("lock_at_96", {31'd0, locked}, 32'd1);
    clean(40);
    chk("clean_bits_41", bit_count, 32'd41);
    chk("clean_errs_0",  err_count, 32'd0);

    // Single flipped bit counts once
    clean(10);
    step(1'b1, 1'b1, 1'b0);
    chk("single_pulse", {31'd0, err_pulse}, 32'd1);
    chk("single_err_1", err_count,          32'd1);
    clean(1);
    chk("single_pulse_off", {31'd0, err_pulse}, 32'd0);

    // Seven errors per window for three windows keeps lock
    align();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 256; i++) step(1'b1, (i % 37) == 5, 1'b0);
    chk("seven_per_win_lock", {31'd0, locked}, 32'd1);
    chk("seven_per_win_errs", err_count,       32'd22);

    // Eight errors in one window drop lock; 95 clean bits reacquire
    align();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k < 7) clean(9);
    end
    chk("eight_errs", err_count, 32'd30);
    clean(1);
    chk("unlocked", {31'd0, locked}, 32'd0);
    clean(94);
    chk("relock_pending", {31'd0, locked}, 32'd0);
    clean(1);
    chk("relocked", {31'd0, locked}, 32'd1);

    // clr coincident with an error: count dropped, pulse kept
    clean(5);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_err_count", err_count,          32'd0);
    chk("clr_err_pulse", {31'd0, err_pulse}, 32'd1);
    chk("clr_bit_count", bit_count,          32'd0);

    // Twenty errors: 4-bit counter wraps to 4 or saturates at 15
    step(1'b1, 1'b0, 1'b1);
    align();
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 256; i++) step(1'b1, (i % 50) == 7, 1'b0);
    chk("twenty_errs_32", err_count, 32'd20);
`ifdef PRBS_CHK_SAT_EN
    chk("twenty_errs_4", {28'd0, err_count4}, 32'd15);
`else
    chk("twenty_errs_4", {28'd0, err_count4}, 32'd4);
`endif

    // Reset mid-stream clears outputs without waiting for a clock
    step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_locked",    {31'd0, locked},    32'd0);
    chk("midrst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("midrst_err_count", err_count,          32'd0);
    chk("midrst_bit_count", bit_count,          32'd0);

    // Random bit_valid gaps: same outcome as the clean run
    do_reset();
    for (int n = 0; n < 136; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("gaps_locked", {31'd0, locked}, 32'd1);
    chk("gaps_bits_41", bit_count,      32'd41);
    chk("gaps_errs_0",  err_count,      32'd0);

    // All-zero input never locks
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 500; i++) raw(1'b0);
    chk("zeros_no_lock", {31'd0, seen_lock}, 32'd0);
    chk("zeros_errs",    err_count,          32'd0);
    chk("zeros_bits",    bit_count,          32'd0);

    // Inverted PRBS31 never locks
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 400; i++) begin
      raw(~gen[30]);
      gen = {gen[29:0], gen[30] ^ gen[27]};
    end
    chk("inv_no_lock", {31'd0, seen_lock}, 32'd0);
    chk("inv_bits",    bit_count,          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
